shared_mailbox: RTL and testbench
=================================

// Module: shared_mailbox
// PURPOSE
//  Per-unit mailbox memory: NUM_UNITS independent circular FIFOs of DEPTH entries each,
//  in one shared storage array. Compute units post mtx_types vectors to a destination unit.
//  Consumers pop them in order with a registered read.
//  Adds over the single-entry store: depth, valid/ready flow control, per-unit occupancy,
//  per-unit flush and bad-ID detection.
// PARAMETERS
//  NUM_UNITS  32                       number of unit mailboxes (>=2)
//  DEPTH      4                        entries per mailbox (power of 2, >=2)
//  DATA_W     $bits(mtx_types::mv_t)   payload width
//  UID_W      $clog2(NUM_UNITS)        localparam, unit-ID width
//  CNT_W      $clog2(DEPTH+1)          localparam, occupancy width
// PORTS
//  clk           in   1               clock, all state on rising edge
//  rst           in   1               asynchronous, active-high reset
//  wr_valid      in   1               write request
//  wr_unit       in   UID_W           destination mailbox
//  wr_data       in   DATA_W          payload
//  wr_ready      out  1               write accepted this cycle when wr_valid&&wr_ready
//  rd_valid      in   1               pop request
//  rd_unit       in   UID_W           mailbox to pop
//  rd_ready      out  1               pop accepted this cycle when rd_valid&&rd_ready
//  rd_data_valid out  1               rd_data/rd_data_unit valid (1-cycle pulse per pop)
//  rd_data       out  DATA_W          popped payload
//  rd_data_unit  out  UID_W           mailbox the payload came from
//  flush_valid   in   1               empty mailbox flush_unit
//  flush_unit    in   UID_W           mailbox to flush
//  level         out  NUM_UNITS*CNT_W occupancy, unit u at [u*CNT_W +: CNT_W], registered
//  err_bad_unit  out  1               sticky: write/pop/flush to unit >= NUM_UNITS
// BEHAVIOUR
//  Reset (async, immediate):
//   - all rd/wr pointers and level = 0; rd_data_valid = 0; rd_data = 0; rd_data_unit = 0; err_bad_unit = 0.
//   - Storage array is not reset.
//  wr_ready (combinational):
//   - 0 if level[wr_unit]==DEPTH, or if flush_valid && flush_unit==wr_unit.
//   - Else 1, including an out-of-range wr_unit.
//  rd_ready (combinational):
//   - 0 if level[rd_unit]==0, or if flush_valid && flush_unit==rd_unit.
//   - 1 for an out-of-range rd_unit.
//  Write accept: mem[wr_unit][wptr] <= wr_data; wptr+1 mod DEPTH; level+1.
//  Pop accept:
//   - next cycle rd_data = mem[rd_unit][rptr], rd_data_unit = rd_unit, rd_data_valid = 1.
//   - rptr+1 mod DEPTH; level-1.
//   - Latency is exactly 1 cycle. rd_data holds its value when rd_data_valid = 0.
//  Same-unit write+pop in one cycle: both proceed and level is unchanged.
//   - Only possible when 0 < level < DEPTH, because readiness is computed from the current level.
//   - There is no empty bypass: a write into an empty mailbox is poppable the next cycle.
//   - Data order is strict FIFO per unit, including across pointer wrap-around.
//  Flush: wptr = rptr = 0, level = 0 at the edge. It overrides any write/pop to the same unit,
//   which are de-asserted via ready. Other units are unaffected.
//  Out-of-range ID (only when NUM_UNITS is not a power of 2):
//   - The write/pop/flush is accepted and dropped; it has no state effect.
//   - err_bad_unit is set until reset. A dropped pop produces no rd_data_valid.
//  Different-unit write, pop and flush may all occur in the same cycle, each independently.
//  Reset during operation: in-flight rd_data_valid clears immediately. All mailboxes read empty
//   after reset release.
// TESTING
//  Fill:
//   - Stimulus: NUM_UNITS=32, DEPTH=4; write A0..A3 to unit 3, then hold wr_valid with A4.
//   - Response: level[3] steps 1..4; wr_ready=0 while A4 is held; unit 4 still accepts.
//  Drain:
//   - Stimulus: pop unit 3 four times back-to-back.
//   - Response: rd_data = A0,A1,A2,A3 on consecutive cycles, each 1 cycle after accept;
//     rd_data_unit=3; rd_ready=0 afterwards.
//  Wrap:
//   - Stimulus: with unit 7 at level 2, write+pop unit 7 every cycle for 10 cycles with data 0..9.
//   - Response: level stays 2; popped order is the two preloads, then 0..7.
//  Flush:
//   - Stimulus: unit 5 at level 3; flush unit 5 and write unit 5 in the same cycle, while unit 6 pops.
//   - Response: wr_ready=0; level[5]=0 next cycle; unit 6 pop completes normally.
//  Bad ID:
//   - Stimulus: NUM_UNITS=24; write to unit 30.
//   - Response: wr_ready=1; no level changes; err_bad_unit=1 until rst.
//  Reset:
//   - Stimulus: assert rst in the cycle after a pop accept.
//   - Response: rd_data_valid=0 immediately; all level=0; rd_ready=0 for every valid unit.

Source files
------------

// File: rtl/shared_mailbox.sv
// Shared mailbox: NUM_UNITS independent circular FIFOs of DEPTH entries in one storage array,
// with valid/ready flow control, registered pop data, per-unit occupancy, flush and bad-ID flag.

package mtx_types;
  typedef struct packed {
    logic [7:0] e3;
    logic [7:0] e2;
    logic [7:0] e1;
    logic [7:0] e0;
  } mv_t;
endpackage

module shared_mailbox #(
  parameter int NUM_UNITS = 32,
  parameter int DEPTH     = 4,
  parameter int DATA_W    = $bits(mtx_types::mv_t),
  localparam int UID_W    = $clog2(NUM_UNITS),
  localparam int CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_valid,
  input  logic [UID_W-1:0]           wr_unit,
  input  logic [DATA_W-1:0]          wr_data,
  output logic                       wr_ready,
  input  logic                       rd_valid,
  input  logic [UID_W-1:0]           rd_unit,
  output logic                       rd_ready,
  output logic                       rd_data_valid,
  output logic [DATA_W-1:0]          rd_data,
  output logic [UID_W-1:0]           rd_data_unit,
  input  logic                       flush_valid,
  input  logic [UID_W-1:0]           flush_unit,
  output logic [NUM_UNITS*CNT_W-1:0] level,
  output logic                       err_bad_unit
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int ADDR_W = UID_W + PTR_W;
  localparam logic [CNT_W-1:0] FULL_LVL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};

  // IDs at or above NUM_UNITS only exist when NUM_UNITS is not a power of two.
  function automatic logic unit_ok(input logic [UID_W-1:0] u);
    return (int'(u) < NUM_UNITS);
  endfunction

  logic [CNT_W-1:0]  level_r [NUM_UNITS];
  logic [PTR_W-1:0]  wptr_r  [NUM_UNITS];
  logic [PTR_W-1:0]  rptr_r  [NUM_UNITS];
  logic [DATA_W-1:0] mem_r   [NUM_UNITS*DEPTH];

  logic                 rd_data_valid_r;
  logic [DATA_W-1:0]    rd_data_r;
  logic [UID_W-1:0]     rd_data_unit_r;
  logic                 err_r;

  logic                 wr_ok_s, rd_ok_s, flush_ok_s;
  logic                 wr_fire_s, rd_fire_s, flush_fire_s, bad_s;
  logic [CNT_W-1:0]     wr_lvl_s, rd_lvl_s;
  logic [ADDR_W-1:0]    wr_addr_s, rd_addr_s;
  logic [NUM_UNITS-1:0] wr_hit_s, rd_hit_s, fl_hit_s;

  // Readiness, accept decode and storage addressing for the current request set.
  always_comb begin
    wr_ok_s    = unit_ok(wr_unit);
    rd_ok_s    = unit_ok(rd_unit);
    flush_ok_s = unit_ok(flush_unit);
    wr_lvl_s   = {CNT_W{1'b0}};
    rd_lvl_s   = {CNT_W{1'b0}};
    wr_addr_s  = {ADDR_W{1'b0}};
    rd_addr_s  = {ADDR_W{1'b0}};
    if (wr_ok_s) begin
      wr_lvl_s  = level_r[wr_unit];
      wr_addr_s = {wr_unit, wptr_r[wr_unit]};
    end else begin
      wr_lvl_s  = {CNT_W{1'b0}};
    end
    if (rd_ok_s) begin
      rd_lvl_s  = level_r[rd_unit];
      rd_addr_s = {rd_unit, rptr_r[rd_unit]};
    end else begin
      rd_lvl_s  = {CNT_W{1'b0}};
    end
    if (wr_ok_s) begin
      wr_ready = (wr_lvl_s != FULL_LVL) && !(flush_valid && (flush_unit == wr_unit));
    end else begin
      wr_ready = 1'b1;
    end
    if (rd_ok_s) begin
      rd_ready = (rd_lvl_s != {CNT_W{1'b0}}) && !(flush_valid && (flush_unit == rd_unit));
    end else begin
      rd_ready = 1'b1;
    end
    wr_fire_s    = wr_valid && wr_ready && wr_ok_s;
    rd_fire_s    = rd_valid && rd_ready && rd_ok_s;
    flush_fire_s = flush_valid && flush_ok_s;
    bad_s        = (wr_valid && !wr_ok_s) || (rd_valid && !rd_ok_s) || (flush_valid && !flush_ok_s);
  end

  // Per-unit one-hot hits for write, pop and flush.
  always_comb begin
    wr_hit_s = {NUM_UNITS{1'b0}};
    rd_hit_s = {NUM_UNITS{1'b0}};
    fl_hit_s = {NUM_UNITS{1'b0}};
    for (int u = 0; u < NUM_UNITS; u++) begin
      wr_hit_s[u] = wr_fire_s && (wr_unit == UID_W'(u));
      rd_hit_s[u] = rd_fire_s && (rd_unit == UID_W'(u));
      fl_hit_s[u] = flush_fire_s && (flush_unit == UID_W'(u));
    end
  end

  // Pointer and occupancy state; flush wins over any same-unit write or pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int u = 0; u < NUM_UNITS; u++) begin
        level_r[u] <= {CNT_W{1'b0}};
        wptr_r[u]  <= {PTR_W{1'b0}};
        rptr_r[u]  <= {PTR_W{1'b0}};
      end
    end else begin
      for (int u = 0; u < NUM_UNITS; u++) begin
        if (fl_hit_s[u]) begin
          level_r[u] <= {CNT_W{1'b0}};
          wptr_r[u]  <= {PTR_W{1'b0}};
          rptr_r[u]  <= {PTR_W{1'b0}};
        end else begin
          if (wr_hit_s[u]) begin
            wptr_r[u] <= wptr_r[u] + PTR_ONE;
          end
          if (rd_hit_s[u]) begin
            rptr_r[u] <= rptr_r[u] + PTR_ONE;
          end
          case ({wr_hit_s[u], rd_hit_s[u]})
            2'b10:   level_r[u] <= level_r[u] + CNT_ONE;
            2'b01:   level_r[u] <= level_r[u] - CNT_ONE;
            default: level_r[u] <= level_r[u];
          endcase
        end
      end
    end
  end

  // Payload storage, intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_fire_s) begin
      mem_r[wr_addr_s] <= wr_data;
    end
  end

  // Registered pop data and sticky bad-ID flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_valid_r <= 1'b0;
      rd_data_r       <= {DATA_W{1'b0}};
      rd_data_unit_r  <= {UID_W{1'b0}};
      err_r           <= 1'b0;
    end else begin
      rd_data_valid_r <= rd_fire_s;
      if (rd_fire_s) begin
        rd_data_r      <= mem_r[rd_addr_s];
        rd_data_unit_r <= rd_unit;
      end
      if (bad_s) begin
        err_r <= 1'b1;
      end
    end
  end

  // Flatten the occupancy registers onto the level bus.
  always_comb begin
    level = {(NUM_UNITS*CNT_W){1'b0}};
    for (int u = 0; u < NUM_UNITS; u++) begin
      level[u*CNT_W +: CNT_W] = level_r[u];
    end
  end

  assign rd_data_valid = rd_data_valid_r;
  assign rd_data       = rd_data_r;
  assign rd_data_unit  = rd_data_unit_r;
  assign err_bad_unit  = err_r;

endmodule

// File: tb/tb_shared_mailbox.sv
// Directed bench for shared_mailbox: a 32-unit instance for FIFO behaviour and a 24-unit
// instance for out-of-range IDs.

module tb_shared_mailbox;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;

  logic        wr_valid, rd_valid, flush_valid;
  logic [4:0]  wr_unit, rd_unit, flush_unit;
  logic [31:0] wr_data;
  logic        wr_ready, rd_ready, rd_data_valid, err_bad_unit;
  logic [31:0] rd_data;
  logic [4:0]  rd_data_unit;
  logic [95:0] level;

  logic        wr_valid_b, rd_valid_b, flush_valid_b;
  logic [4:0]  wr_unit_b, rd_unit_b, flush_unit_b;
  logic [31:0] wr_data_b;
  logic        wr_ready_b, rd_ready_b, rd_data_valid_b, err_bad_unit_b;
  logic [31:0] rd_data_b;
  logic [4:0]  rd_data_unit_b;
  logic [71:0] level_b;

  shared_mailbox #(.NUM_UNITS(32), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_unit(wr_unit), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_valid(rd_valid), .rd_unit(rd_unit), .rd_ready(rd_ready),
    .rd_data_valid(rd_data_valid), .rd_data(rd_data), .rd_data_unit(rd_data_unit),
    .flush_valid(flush_valid), .flush_unit(flush_unit),
    .level(level), .err_bad_unit(err_bad_unit)
  );

  shared_mailbox #(.NUM_UNITS(24), .DEPTH(4)) dut_b (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid_b), .wr_unit(wr_unit_b), .wr_data(wr_data_b), .wr_ready(wr_ready_b),
    .rd_valid(rd_valid_b), .rd_unit(rd_unit_b), .rd_ready(rd_ready_b),
    .rd_data_valid(rd_data_valid_b), .rd_data(rd_data_b), .rd_data_unit(rd_data_unit_b),
    .flush_valid(flush_valid_b), .flush_unit(flush_unit_b),
    .level(level_b), .err_bad_unit(err_bad_unit_b)
  );

  function automatic logic [2:0] lvl(input int u);
    return level[u*3 +: 3];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    wr_valid = 1'b0; rd_valid = 1'b0; flush_valid = 1'b0;
    wr_unit = 5'd0; rd_unit = 5'd0; flush_unit = 5'd0; wr_data = 32'd0;
    wr_valid_b = 1'b0; rd_valid_b = 1'b0; flush_valid_b = 1'b0;
    wr_unit_b = 5'd0; rd_unit_b = 5'd0; flush_unit_b = 5'd0; wr_data_b = 32'd0;
    rst = 1'b1;
    tick(); tick();
    total++; if (rd_data_valid !== 1'b0) $display("FAIL reset_rdv got %b want 0", rd_data_valid); else passed++;
    total++; if (rd_data !== 32'd0) $display("FAIL reset_rd_data got %h want 0", rd_data); else passed++;
    total++; if (rd_data_unit !== 5'd0) $display("FAIL reset_rd_unit got %0d want 0", rd_data_unit); else passed++;
    total++; if (err_bad_unit !== 1'b0) $display("FAIL reset_err got %b want 0", err_bad_unit); else passed++;
    total++; if (level !== 96'd0) $display("FAIL reset_level got %h want 0", level); else passed++;
    total++; if (rd_ready !== 1'b0) $display("FAIL reset_rd_ready got %b want 0", rd_ready); else passed++;
    total++; if (err_bad_unit_b !== 1'b0) $display("FAIL reset_err_b got %b want 0", err_bad_unit_b); else passed++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1; wr_unit = 5'd3; wr_data = 32'hA000_0000 + 32'(i);
      #1;
      total++; if (wr_ready !== 1'b1) $display("FAIL fill_ready%0d got %b want 1", i, wr_ready); else passed++;
      tick();
      total++; if (lvl(3) !== 3'(i + 1)) $display("FAIL fill_level%0d got %0d want %0d", i, lvl(3), i + 1); else passed++;
    end
    wr_data = 32'hA000_0004;
    #1;
    total++; if (wr_ready !== 1'b0) $display("FAIL fill_full_ready got %b want 0", wr_ready); else passed++;
    tick();
    total++; if (lvl(3) !== 3'd4) $display("FAIL fill_full_level got %0d want 4", lvl(3)); else passed++;
    total++; if (wr_ready !== 1'b0) $display("FAIL fill_held_ready got %b want 0", wr_ready); else passed++;
    wr_unit = 5'd4;
    #1;
    total++; if (wr_ready !== 1'b1) $display("FAIL fill_other_ready got %b want 1", wr_ready); else passed++;
    tick();
    wr_valid = 1'b0;
    total++; if (lvl(4) !== 3'd1) $display("FAIL fill_other_level got %0d want 1", lvl(4)); else passed++;
  endtask

  task automatic test_drain();
    for (int k = 0; k < 4; k++) begin
      rd_valid = 1'b1; rd_unit = 5'd3;
      #1;
      total++; if (rd_ready !== 1'b1) $display("FAIL drain_ready%0d got %b want 1", k, rd_ready); else passed++;
      tick();
      total++; if (rd_data_valid !== 1'b1) $display("FAIL drain_rdv%0d got %b want 1", k, rd_data_valid); else passed++;
      total++; if (rd_data !== 32'hA000_0000 + 32'(k)) $display("FAIL drain_data%0d got %h want %h", k, rd_data, 32'hA000_0000 + 32'(k)); else passed++;
      total++; if (rd_data_unit !== 5'd3) $display("FAIL drain_unit%0d got %0d want 3", k, rd_data_unit); else passed++;
      total++; if (lvl(3) !== 3'(3 - k)) $display("FAIL drain_level%0d got %0d want %0d", k, lvl(3), 3 - k); else passed++;
    end
    rd_valid = 1'b0;
    #1;
    total++; if (rd_ready !== 1'b0) $display("FAIL drain_empty_ready got %b want 0", rd_ready); else passed++;
    tick();
    total++; if (rd_data_valid !== 1'b0) $display("FAIL drain_rdv_low got %b want 0", rd_data_valid); else passed++;
    total++; if (rd_data !== 32'hA000_0003) $display("FAIL drain_hold got %h want a0000003", rd_data); else passed++;
  endtask

  task automatic test_wrap();
    logic [31:0] exp;
    for (int i = 0; i < 2; i++) begin
      wr_valid = 1'b1; wr_unit = 5'd7; wr_data = 32'h7700_0000 + 32'(i);
      tick();
    end
    total++; if (lvl(7) !== 3'd2) $display("FAIL wrap_preload got %0d want 2", lvl(7)); else passed++;
    for (int j = 0; j < 10; j++) begin
      wr_valid = 1'b1; wr_unit = 5'd7; wr_data = 32'(j);
      rd_valid = 1'b1; rd_unit = 5'd7;
      #1;
      total++; if ({wr_ready, rd_ready} !== 2'b11) $display("FAIL wrap_ready%0d got %b want 11", j, {wr_ready, rd_ready}); else passed++;
      tick();
      exp = (j < 2) ? 32'h7700_0000 + 32'(j) : 32'(j - 2);
      total++; if (rd_data !== exp) $display("FAIL wrap_data%0d got %h want %h", j, rd_data, exp); else passed++;
      total++; if (lvl(7) !== 3'd2) $display("FAIL wrap_level%0d got %0d want 2", j, lvl(7)); else passed++;
    end
    wr_valid = 1'b0; rd_valid = 1'b0;
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1'b1; wr_unit = 5'd5; wr_data = 32'h5500_0000 + 32'(i);
      tick();
    end
    wr_unit = 5'd6; wr_data = 32'h6600_0000;
    tick();
    total++; if (lvl(5) !== 3'd3) $display("FAIL flush_pre_level got %0d want 3", lvl(5)); else passed++;
    flush_valid = 1'b1; flush_unit = 5'd5;
    wr_valid = 1'b1; wr_unit = 5'd5; wr_data = 32'h55FF_FFFF;
    rd_valid = 1'b1; rd_unit = 5'd6;
    #1;
    total++; if (wr_ready !== 1'b0) $display("FAIL flush_wr_ready got %b want 0", wr_ready); else passed++;
    total++; if (rd_ready !== 1'b1) $display("FAIL flush_rd_ready got %b want 1", rd_ready); else passed++;
    tick();
    flush_valid = 1'b0; wr_valid = 1'b0; rd_valid = 1'b0;
    total++; if (lvl(5) !== 3'd0) $display("FAIL flush_level got %0d want 0", lvl(5)); else passed++;
    total++; if (rd_data_valid !== 1'b1) $display("FAIL flush_other_rdv got %b want 1", rd_data_valid); else passed++;
    total++; if (rd_data !== 32'h6600_0000) $display("FAIL flush_other_data got %h want 66000000", rd_data); else passed++;
    total++; if (rd_data_unit !== 5'd6) $display("FAIL flush_other_unit got %0d want 6", rd_data_unit); else passed++;
    total++; if (lvl(7) !== 3'd2) $display("FAIL flush_untouched got %0d want 2", lvl(7)); else passed++;
    wr_valid = 1'b1; wr_unit = 5'd5; wr_data = 32'h5A5A_0001;
    tick();
    wr_valid = 1'b0; rd_valid = 1'b1; rd_unit = 5'd5;
    tick();
    rd_valid = 1'b0;
    total++; if (rd_data !== 32'h5A5A_0001) $display("FAIL flush_reuse_data got %h want 5a5a0001", rd_data); else passed++;
    total++; if (lvl(5) !== 3'd0) $display("FAIL flush_reuse_level got %0d want 0", lvl(5)); else passed++;
  endtask

  task automatic test_bad_id();
    wr_valid_b = 1'b1; wr_unit_b = 5'd30; wr_data_b = 32'hBAD0_0000;
    #1;
    total++; if (wr_ready_b !== 1'b1) $display("FAIL bad_wr_ready got %b want 1", wr_ready_b); else passed++;
    tick();
    wr_valid_b = 1'b0;
    total++; if (level_b !== 72'd0) $display("FAIL bad_level got %h want 0", level_b); else passed++;
    total++; if (err_bad_unit_b !== 1'b1) $display("FAIL bad_err got %b want 1", err_bad_unit_b); else passed++;
    rd_valid_b = 1'b1; rd_unit_b = 5'd30;
    #1;
    total++; if (rd_ready_b !== 1'b1) $display("FAIL bad_rd_ready got %b want 1", rd_ready_b); else passed++;
    tick();
    rd_valid_b = 1'b0;
    total++; if (rd_data_valid_b !== 1'b0) $display("FAIL bad_rdv got %b want 0", rd_data_valid_b); else passed++;
    tick(); tick();
    total++; if (err_bad_unit_b !== 1'b1) $display("FAIL bad_err_sticky got %b want 1", err_bad_unit_b); else passed++;
    total++; if (err_bad_unit !== 1'b0) $display("FAIL bad_err_pow2 got %b want 0", err_bad_unit); else passed++;
  endtask

  task automatic test_reset_midflight();
    rd_valid = 1'b1; rd_unit = 5'd4;
    tick();
    rd_valid = 1'b0;
    total++; if (rd_data_valid !== 1'b1) $display("FAIL rst_pre_rdv got %b want 1", rd_data_valid); else passed++;
    total++; if (rd_data !== 32'hA000_0004) $display("FAIL rst_pre_data got %h want a0000004", rd_data); else passed++;
    rst = 1'b1;
    #1;
    total++; if (rd_data_valid !== 1'b0) $display("FAIL rst_rdv got %b want 0", rd_data_valid); else passed++;
    total++; if (level !== 96'd0) $display("FAIL rst_level got %h want 0", level); else passed++;
    total++; if (err_bad_unit_b !== 1'b0) $display("FAIL rst_err_b got %b want 0", err_bad_unit_b); else passed++;
    tick();
    rst = 1'b0;
    tick();
    for (int u = 0; u < 32; u++) begin
      rd_unit = 5'(u);
      #1;
      total++; if (rd_ready !== 1'b0) $display("FAIL rst_rd_ready%0d got %b want 0", u, rd_ready); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_flush();
    test_bad_id();
    test_reset_midflight();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
